// File: rtl/mode_sequencer.sv
// Three-phase (LOAD/COMPUTE/STORE) sequencer that drives the scalable up counter.
// Optional MODE_SEQ_REPEAT_EN adds rep_i so COMPUTE runs rep_i+1 times.
module mode_sequencer #(
  parameter int CNT_W = 8,
  parameter int PH_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_load_i,
  input  logic [CNT_W-1:0] len_comp_i,
  input  logic [CNT_W-1:0] len_store_i,
  input  logic             stall_i,
`ifdef MODE_SEQ_REPEAT_EN
  input  logic [3:0]       rep_i,
`endif
  input  logic             cnt_done_i,
  output logic             cnt_en_o,
  output logic [CNT_W-1:0] cnt_num_o,
  output logic [PH_W-1:0]  phase_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    IDLE, SET_LD, RUN_LD, SET_CP, RUN_CP, SET_ST, RUN_ST, FIN
  } state_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] len_ld, len_cp, len_st;
  logic [CNT_W-1:0] ld_nxt, cp_nxt, st_nxt, num_nxt;
  logic [PH_W-1:0]  phase_nxt;
  logic             accept, run_state, fire;
`ifdef MODE_SEQ_REPEAT_EN
  logic [3:0]       rep_cnt;
`endif

  assign accept    = (state == IDLE) && start_i;
  assign run_state = (state == RUN_LD) || (state == RUN_CP) || (state == RUN_ST);
  assign cnt_en_o  = run_state && !stall_i;
  assign fire      = cnt_en_o && cnt_done_i;

  // Lengths as they will be after this edge, so registered outputs can use them on accept.
  assign ld_nxt = accept ? len_load_i  : len_ld;
  assign cp_nxt = accept ? len_comp_i  : len_cp;
  assign st_nxt = accept ? len_store_i : len_st;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (accept) nxt = SET_LD;
      SET_LD: nxt = (len_ld == '0) ? SET_CP : RUN_LD;
      RUN_LD: if (fire) nxt = SET_CP;
      SET_CP: nxt = (len_cp == '0) ? SET_ST : RUN_CP;
      RUN_CP: if (fire) begin
`ifdef MODE_SEQ_REPEAT_EN
        nxt = (rep_cnt != 4'd0) ? SET_CP : SET_ST;
`else
        nxt = SET_ST;
`endif
      end
      SET_ST: nxt = (len_st == '0) ? FIN : RUN_ST;
      RUN_ST: if (fire) nxt = FIN;
      FIN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    num_nxt   = '0;
    phase_nxt = '0;
    case (nxt)
      SET_LD, RUN_LD: begin num_nxt = ld_nxt; phase_nxt = PH_W'(1); end
      SET_CP, RUN_CP: begin num_nxt = cp_nxt; phase_nxt = PH_W'(2); end
      SET_ST, RUN_ST: begin num_nxt = st_nxt; phase_nxt = PH_W'(3); end
      FIN:            phase_nxt = PH_W'(4);
      default:        phase_nxt = '0;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      len_ld    <= '0;
      len_cp    <= '0;
      len_st    <= '0;
      cnt_num_o <= '0;
      phase_o   <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
`ifdef MODE_SEQ_REPEAT_EN
      rep_cnt   <= 4'd0;
`endif
    end else begin
      state     <= nxt;
      len_ld    <= ld_nxt;
      len_cp    <= cp_nxt;
      len_st    <= st_nxt;
      cnt_num_o <= num_nxt;
      phase_o   <= phase_nxt;
      busy_o    <= (nxt != IDLE);
      done_o    <= (nxt == FIN);
`ifdef MODE_SEQ_REPEAT_EN
      if (accept)
        rep_cnt <= rep_i;
      else if ((state == RUN_CP) && fire && (rep_cnt != 4'd0))
        rep_cnt <= rep_cnt - 4'd1;
`endif
    end
  end

endmodule
